// File: rtl/lap_board_char_gen.sv
// lap_board_char_gen: race lap stopwatch with a DEPTH-row lap history, best-lap tracking and a
// registered char_xy -> char_code lookup for the HUD text box.
// Optional minute digit: define LAP_BOARD_MINUTES_EN (field "M:SS:CC" instead of "SS:CC").
module lap_board_char_gen #(
  parameter int unsigned CLK_HZ  = 65_000_000,
  parameter int unsigned TICK_HZ = 100,
  parameter int unsigned DEPTH   = 3
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        lap,
  input  logic        clear,
  input  logic [15:0] char_xy,
  output logic [6:0]  char_code,
  output logic        running,
  output logic [7:0]  lap_count
);

  localparam int unsigned Div = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (Div > 1) ? $clog2(Div) : 1;

`ifdef LAP_BOARD_MINUTES_EN
  localparam int unsigned TW = 20;
  // Saturation value; each nibble is also that digit's roll-over limit.
  localparam logic [TW-1:0] TMax = 20'h95999;
`else
  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] TMax = 16'h9999;
`endif

  typedef enum logic {StStopped, StRunning} state_e;

  state_e                   state_q, state_d;
  logic [PW-1:0]            presc_q, presc_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [DEPTH-1:0][TW-1:0] hist_q, hist_d;
  logic [DEPTH-1:0]         hist_vld_q, hist_vld_d;
  logic [TW-1:0]            best_q, best_d;
  logic                     best_vld_q, best_vld_d;
  logic [7:0]               lap_cnt_q, lap_cnt_d;
  logic [6:0]               char_q, char_d;
  logic                     tick;

  // Saturating BCD increment; digits roll over at the matching TMax nibble.
  function automatic logic [TW-1:0] bcd_inc(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    logic          carry;
    r = t;
    if (t != TMax) begin
      carry = 1'b1;
      for (int i = 0; i < int'(TW / 4); i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == TMax[i*4 +: 4]) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Run/stop state: stop wins over a simultaneous start.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = StStopped;
    end else if (start) begin
      state_d = StRunning;
    end
  end

  // Stopwatch, lap history and best-lap next state; clear beats lap.
  always_comb begin
    tick       = (state_q == StRunning) && (presc_q == PW'(Div - 1));
    presc_d    = presc_q;
    timer_d    = timer_q;
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    best_d     = best_q;
    best_vld_d = best_vld_q;
    lap_cnt_d  = lap_cnt_q;
    if (clear) begin
      presc_d    = '0;
      timer_d    = '0;
      hist_vld_d = '0;
      best_vld_d = 1'b0;
      lap_cnt_d  = '0;
    end else if (lap && (state_q == StRunning)) begin
      for (int k = int'(DEPTH) - 1; k > 0; k--) begin
        hist_d[k]     = hist_q[k-1];
        hist_vld_d[k] = hist_vld_q[k-1];
      end
      // Pre-tick value is captured; a tick on this edge is dropped.
      hist_d[0]     = timer_q;
      hist_vld_d[0] = 1'b1;
      if (!best_vld_q || (timer_q < best_q)) begin
        best_d     = timer_q;
        best_vld_d = 1'b1;
      end
      timer_d = '0;
      presc_d = '0;
      if (lap_cnt_q != 8'hFF) begin
        lap_cnt_d = lap_cnt_q + 8'd1;
      end
    end else if (state_q == StRunning) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        timer_d = bcd_inc(timer_q);
      end
    end
  end

  logic [7:0]    cx, cy;
  logic [TW-1:0] fld;
  logic          fld_vld, row_ok, is_lap, is_dig, is_col;
  logic [6:0]    label;
  logic [3:0]    dig;

  // Character lookup: row picks the value/label set, column picks label, digit or colon.
  always_comb begin
    cx      = char_xy[15:8];
    cy      = char_xy[7:0];
    fld     = timer_q;
    fld_vld = 1'b1;
    row_ok  = (cy == 8'd0);
    is_lap  = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (cy == 8'(k + 1)) begin
        row_ok  = 1'b1;
        is_lap  = 1'b1;
        fld     = hist_q[k];
        fld_vld = hist_vld_q[k];
      end
    end
    if (cy == 8'(DEPTH + 1)) begin
      row_ok  = 1'b1;
      fld     = best_q;
      fld_vld = best_vld_q;
    end

    // Labels: "TIME: ", "LAP k:", "BEST: "; col 6 is a space.
    case (cx)
      8'd0:    label = is_lap ? 7'h4C : (cy == 8'd0) ? 7'h54 : 7'h42;
      8'd1:    label = is_lap ? 7'h41 : (cy == 8'd0) ? 7'h49 : 7'h45;
      8'd2:    label = is_lap ? 7'h50 : (cy == 8'd0) ? 7'h4D : 7'h53;
      8'd3:    label = is_lap ? 7'h20 : (cy == 8'd0) ? 7'h45 : 7'h54;
      8'd4:    label = is_lap ? (7'h30 + cy[6:0]) : 7'h3A;
      8'd5:    label = is_lap ? 7'h3A : 7'h20;
      default: label = 7'h20;
    endcase

    is_dig = 1'b0;
    is_col = 1'b0;
    dig    = 4'd0;
    case (cx)
`ifdef LAP_BOARD_MINUTES_EN
      8'd7:  begin is_dig = 1'b1; dig = fld[19:16]; end
      8'd8:  is_col = 1'b1;
      8'd9:  begin is_dig = 1'b1; dig = fld[15:12]; end
      8'd10: begin is_dig = 1'b1; dig = fld[11:8];  end
      8'd11: is_col = 1'b1;
      8'd12: begin is_dig = 1'b1; dig = fld[7:4];   end
      8'd13: begin is_dig = 1'b1; dig = fld[3:0];   end
`else
      8'd7:  begin is_dig = 1'b1; dig = fld[15:12]; end
      8'd8:  begin is_dig = 1'b1; dig = fld[11:8];  end
      8'd9:  is_col = 1'b1;
      8'd10: begin is_dig = 1'b1; dig = fld[7:4];   end
      8'd11: begin is_dig = 1'b1; dig = fld[3:0];   end
`endif
      default: ;
    endcase

    char_d = 7'h00;
    if (row_ok) begin
      if (cx < 8'd7) begin
        char_d = label;
      end else if (is_dig) begin
        char_d = fld_vld ? (7'h30 + {3'b000, dig}) : 7'h2D;
      end else if (is_col) begin
        char_d = 7'h3A;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= StStopped;
      presc_q    <= '0;
      timer_q    <= '0;
      hist_q     <= '0;
      hist_vld_q <= '0;
      best_q     <= '0;
      best_vld_q <= 1'b0;
      lap_cnt_q  <= '0;
      char_q     <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      timer_q    <= timer_d;
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
      best_q     <= best_d;
      best_vld_q <= best_vld_d;
      lap_cnt_q  <= lap_cnt_d;
      char_q     <= char_d;
    end
  end

  assign char_code = char_q;
  assign running   = (state_q == StRunning);
  assign lap_count = lap_cnt_q;

endmodule

// File: tb/tb_lap_board_char_gen.sv
// Bench for lap_board_char_gen: directed plan steps plus random pulses, checked against a
// centisecond-integer reference model that renders rows as strings.
module tb_lap_board_char_gen;

  localparam int unsigned CLK_HZ  = 200;
  localparam int unsigned TICK_HZ = 100;
  localparam int unsigned DEPTH   = 3;
  localparam int          Div     = CLK_HZ / TICK_HZ;
`ifdef LAP_BOARD_MINUTES_EN
  localparam int CsMax  = 59999;
  localparam int RowLen = 14;
`else
  localparam int CsMax  = 9999;
  localparam int RowLen = 12;
`endif

  logic        pclk, rst, start, stop, lap, clear;
  logic [15:0] char_xy;
  logic [6:0]  char_code;
  logic        running;
  logic [7:0]  lap_count;

  lap_board_char_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .DEPTH  (DEPTH)
  ) dut (
    .pclk     (pclk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .lap      (lap),
    .clear    (clear),
    .char_xy  (char_xy),
    .char_code(char_code),
    .running  (running),
    .lap_count(lap_count)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: times held as plain centisecond counts.
  bit m_run;
  int m_cs, m_pc, m_best, m_lapcnt;
  bit m_best_v;
  int m_hist[$];

  function automatic string fmt(input int v, input bit valid);
`ifdef LAP_BOARD_MINUTES_EN
    if (!valid) return "-:--:--";
    return $sformatf("%0d:%02d:%02d", v / 6000, (v / 100) % 60, v % 100);
`else
    if (!valid) return "--:--";
    return $sformatf("%02d:%02d", v / 100, v % 100);
`endif
  endfunction

  function automatic logic [6:0] model_char(input int x, input int y);
    string s;
    byte   b;
    if (y == 0) s = $sformatf("TIME:  %s", fmt(m_cs, 1'b1));
    else if (y <= int'(DEPTH))
      s = $sformatf("LAP %0d: %s", y, fmt((y <= m_hist.size()) ? m_hist[y-1] : 0,
                                         y <= m_hist.size()));
    else if (y == int'(DEPTH) + 1) s = $sformatf("BEST:  %s", fmt(m_best, m_best_v));
    else return 7'h00;
    if (x >= s.len()) return 7'h00;
    b = s[x];
    return b[6:0];
  endfunction

  task automatic model_step();
    bit tick;
    if (rst) begin
      m_run = 0; m_cs = 0; m_pc = 0; m_hist.delete(); m_best_v = 0; m_lapcnt = 0;
      return;
    end
    tick = m_run && (m_pc == Div - 1);
    if (clear) begin
      m_cs = 0; m_pc = 0; m_hist.delete(); m_best_v = 0; m_lapcnt = 0;
    end else if (lap && m_run) begin
      m_hist.push_front(m_cs);
      if (m_hist.size() > int'(DEPTH)) void'(m_hist.pop_back());
      if (!m_best_v || m_cs < m_best) begin
        m_best = m_cs;
        m_best_v = 1;
      end
      m_cs = 0;
      m_pc = 0;
      if (m_lapcnt < 255) m_lapcnt++;
    end else if (m_run) begin
      m_pc = tick ? 0 : m_pc + 1;
      if (tick && m_cs < CsMax) m_cs++;
    end
    if (stop) m_run = 0;
    else if (start) m_run = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    n_chk++;
    assert (obs == exp)
    else begin
      n_err++;
      $error("FAIL %s: got \"%s\" expected \"%s\"", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later, pulses dropped.
  task automatic cycle();
    logic [6:0] exp_c;
    @(posedge pclk);
    exp_c = rst ? 7'h00 : model_char(int'(char_xy[15:8]), int'(char_xy[7:0]));
    model_step();
    #1;
    chk("char_code", {25'b0, char_code}, {25'b0, exp_c});
    chk("running", {31'b0, running}, {31'b0, m_run});
    chk("lap_count", {24'b0, lap_count}, m_lapcnt);
    start = 0; stop = 0; lap = 0; clear = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      char_xy = {8'($urandom_range(15)), 8'($urandom_range(6))};
      cycle();
    end
  endtask

  task automatic read_row(input int y, output string s);
    s = "";
    for (int x = 0; x < RowLen; x++) begin
      char_xy = {8'(x), 8'(y)};
      cycle();
      s = $sformatf("%s%c", s, char_code);
    end
  endtask

  task automatic lap_after(input int ticks);
    idle(ticks * Div);
    lap = 1;
    cycle();
  endtask

  string row;

  initial begin
    rst = 1; start = 0; stop = 0; lap = 0; clear = 0; char_xy = 16'h0000;
    cycle();
    cycle();
    chk("rst_char", {25'b0, char_code}, 32'h0);
    chk("rst_running", {31'b0, running}, 32'h0);
    chk("rst_lap_count", {24'b0, lap_count}, 32'h0);
    rst = 0;
    cycle();
    chk("row0_col0_T", {25'b0, char_code}, 32'h54);
    char_xy = {8'd7, 8'd1};
    cycle();
    chk("lap1_dash", {25'b0, char_code}, 32'h2D);
    char_xy = {8'd9, 8'd1};
    cycle();
    chk("lap1_colon", {25'b0, char_code}, 32'h3A);

`ifdef LAP_BOARD_MINUTES_EN
    start = 1;
    cycle();
    idle(6150 * Div - 1);
    stop = 1;
    cycle();
    read_row(0, row);
    chk_str("time_6150", row, "TIME:  1:01:50");
`else
    // 123 ticks then freeze.
    start = 1;
    cycle();
    idle(123 * Div - 1);
    stop = 1;
    cycle();
    read_row(0, row);
    chk_str("time_123", row, "TIME:  01:23");
    idle(50);
    read_row(0, row);
    chk_str("time_frozen", row, "TIME:  01:23");
    start = 1; stop = 1;
    cycle();
    chk("start_stop_same", {31'b0, running}, 32'h0);

    // Three laps.
    clear = 1;
    cycle();
    start = 1;
    cycle();
    lap_after(250);
    lap_after(120);
    lap_after(300);
    stop = 1;
    cycle();
    read_row(1, row); chk_str("lap1_a", row, "LAP 1: 03:00");
    read_row(2, row); chk_str("lap2_a", row, "LAP 2: 01:20");
    read_row(3, row); chk_str("lap3_a", row, "LAP 3: 02:50");
    read_row(4, row); chk_str("best_a", row, "BEST:  01:20");
    chk("lap_count_3", {24'b0, lap_count}, 32'd3);

    // Fourth lap equal to best; oldest dropped.
    start = 1;
    cycle();
    lap_after(120);
    stop = 1;
    cycle();
    read_row(1, row); chk_str("lap1_b", row, "LAP 1: 01:20");
    read_row(2, row); chk_str("lap2_b", row, "LAP 2: 03:00");
    read_row(3, row); chk_str("lap3_b", row, "LAP 3: 01:20");
    read_row(4, row); chk_str("best_b", row, "BEST:  01:20");
    lap = 1;
    cycle();
    chk("lap_stopped_count", {24'b0, lap_count}, 32'd4);
    read_row(1, row); chk_str("lap_stopped_row", row, "LAP 1: 01:20");

    // Saturation, then a lap on a tick edge.
    start = 1;
    cycle();
    idle(10050 * Div);
    read_row(0, row);
    chk_str("time_sat", row, "TIME:  99:99");
    for (int i = 0; i < Div && m_pc != Div - 1; i++) idle(1);
    lap = 1;
    cycle();
    stop = 1;
    cycle();
    read_row(0, row); chk_str("time_after_lap", row, "TIME:  00:00");
    read_row(1, row); chk_str("lap1_sat", row, "LAP 1: 99:99");
    chk("lap_count_5", {24'b0, lap_count}, 32'd5);
    clear = 1;
    cycle();
    read_row(1, row); chk_str("clr_lap1", row, "LAP 1: --:--");
    read_row(3, row); chk_str("clr_lap3", row, "LAP 3: --:--");
    read_row(4, row); chk_str("clr_best", row, "BEST:  --:--");
    chk("clr_lap_count", {24'b0, lap_count}, 32'd0);
`endif

    // Random pulses including occasional reset.
    for (int i = 0; i < 4000; i++) begin
      char_xy = {8'($urandom_range(15)), 8'($urandom_range(6))};
      start = ($urandom_range(7) == 0);
      stop  = ($urandom_range(15) == 0);
      lap   = ($urandom_range(19) == 0);
      clear = ($urandom_range(99) == 0);
      rst   = ($urandom_range(499) == 0);
      cycle();
      rst = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
